load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage consumer of the decoder's loadStore/memWrite/funct3 outputs.
- Turns one RV32I load or store into a single word-aligned request on the data-memory valid/ready bus, with byte enables and store-lane replication.
- For loads, returns the byte/half/word result sign- or zero-extended.
- Holds the pipeline via stall until the access completes. Flags misaligned accesses and bus timeouts instead of issuing them.

Parameters:
- TIMEOUT_CYCLES, 255: cycles allowed in REQ+RESP before a bus error is flagged. 0 disables the timeout. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  clock, rising edge
- rstN  in  1  synchronous, active-low reset
- loadStore  in  1  memory instruction present in this stage
- memWrite  in  1  1=store, 0=load (qualified by loadStore)
- funct3  in  3  [1:0] size: 00 byte, 01 half, 10 word; [2] unsigned load
- addr  in  32  effective address (ALU result)
- storeData  in  32  rs2 value
- stall  out  1  hold the pipeline
- opDone  out  1  one-cycle completion pulse
- loadData  out  32  extended load result, valid while opDone=1
- misaligned  out  1  accompanies opDone; access not issued
- busErr  out  1  accompanies opDone; timeout occurred
- memReq  out  1  bus request
- memWe  out  1  bus write
- memAddr  out  32  {addr[31:2],2'b00}
- memBe  out  4  byte enables
- memWdata  out  32  lane-replicated store data
- memReady  in  1  request accepted this cycle when memReq=1
- memRvalid  in  1  read data valid
- memRdata  in  32  read word

Behaviour:
- Reset (rstN=0 at edge): state IDLE. memReq, memWe, opDone, misaligned, busErr = 0. memAddr, memBe, memWdata, loadData = 0. Timeout counter = 0. Reset mid-transaction abandons it. memReq drops at that edge. A later memRvalid is ignored.
- States: IDLE, REQ, RESP, DONE.
- stall = (state==IDLE && loadStore) || state==REQ || state==RESP. stall is combinational. It is 0 in DONE.
- IDLE:
  - On loadStore, latch memWrite, funct3, addr[1:0], storeData.
  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=11. Misaligned goes to DONE with misaligned=1, loadData=0, and no bus activity.
  - Otherwise go to REQ. memReq, memWe, memAddr, memBe, memWdata are registered and valid from the first REQ cycle.
- memBe: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'hF.
- memWdata: byte = {4{storeData[7:0]}}; half = {2{storeData[15:0]}}; word = storeData.
- REQ:
  - memReq is held with all bus fields stable until memReady=1.
  - Store accepted: go to DONE.
  - Load accepted: go to RESP. memReq falls at that edge.
  - If memRvalid and memReady arrive in the same cycle for a load, capture the data and go straight to DONE.
- RESP: wait for memRvalid, then capture and extend the lane selected by the latched addr[1:0] and funct3, and go to DONE.
- Timeout: the counter increments every REQ/RESP cycle and is cleared in IDLE. When it reaches TIMEOUT_CYCLES, go to DONE with busErr=1 and loadData=0. memReq drops.
- DONE: exactly one cycle. opDone=1. loadData, misaligned, busErr are registered and valid. Then go to IDLE. loadStore is ignored in DONE, because the same instruction is still present before the pipeline advances.
- Latency: an aligned load with memReady and memRvalid in the first REQ cycle has opDone in cycle 2 after loadStore is seen. Stall is high for cycles 0-1.
- Back-to-back: an instruction seen in IDLE the cycle after DONE starts normally.

Decomposition:
- Shared package core_pkg:
  - funct3 size constants (SIZE_B, SIZE_H, SIZE_W)
  - lsu_state_t enum {IDLE, REQ, RESP, DONE}
  - bus width localparams
- One natural combinational sub-module, load_align: inputs rdata, addrLo[1:0], funct3; output is the 32-bit extended result. It is reused by any future cache path.

Test Plan:
- Store word: addr=0x100, storeData=0xDEADBEEF, memReady=1 in the first REQ cycle -> memAddr=0x100, memBe=4'hF, memWe=1 for one cycle; opDone in cycle 2; stall high cycles 0-1.
- Store byte: addr=0x103, storeData=0x000000A5 -> memBe=4'b1000, memWdata=0xA5A5A5A5, memAddr=0x100.
- Load byte signed: addr=0x201, memRdata=0x00008000 (data lands one cycle after memReady) -> loadData=0xFFFFFF80; the same case with funct3=100 gives loadData=0x00000080.
- Load half: addr=0x302, funct3=001, memRdata=0x80010000 -> loadData=0xFFFF8001.
- Misaligned word: addr=0x105 -> memReq never asserted; opDone=1 with misaligned=1 in cycle 1.
- Timeout with TIMEOUT_CYCLES=4, memReady held 0 -> busErr=1 with opDone after 4 REQ cycles; memReq then 0. A second test pulls rstN low during RESP -> memReq=0 and state IDLE after that edge, and a following stray memRvalid produces no opDone.

Source files
------------

// File: rtl/core_pkg.sv
// Shared memory-stage definitions: access sizes, LSU states, bus widths
// and the small helpers that shape a request for the data bus.
package core_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  // funct3[1:0] access size encodings
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } lsu_state_t;

  // Size 11 is never legal, so it is reported the same way as a bad offset
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lo[0];
      SIZE_W:  bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [BE_W-1:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
    logic [BE_W-1:0] be;
    be = '0;
    case (size)
      SIZE_B:  be = 4'b0001 << lo;
      SIZE_H:  be = 4'b0011 << lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data is replicated across every lane so memory can simply honour the byte enables
  function automatic logic [XLEN-1:0] store_lanes(input logic [1:0] size, input logic [XLEN-1:0] data);
    logic [XLEN-1:0] w;
    w = data;
    case (size)
      SIZE_B:  w = {4{data[7:0]}};
      SIZE_H:  w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module load_align
  import core_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addrLo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension; funct3[2] selects zero-extension
  always_comb begin
    byte_sel = rdata[{addrLo, 3'b000} +: 8];
    half_sel = addrLo[1] ? rdata[31:16] : rdata[15:0];
    result   = '0;
    case (funct3[1:0])
      SIZE_B:  result = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SIZE_H:  result = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      SIZE_W:  result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one RV32I access becomes one word-aligned
// valid/ready bus transaction, with stall held until it completes.
module load_store_unit
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            loadStore,
  input  logic            memWrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] storeData,
  output logic            stall,
  output logic            opDone,
  output logic [XLEN-1:0] loadData,
  output logic            misaligned,
  output logic            busErr,
  output logic            memReq,
  output logic            memWe,
  output logic [XLEN-1:0] memAddr,
  output logic [BE_W-1:0] memBe,
  output logic [XLEN-1:0] memWdata,
  input  logic            memReady,
  input  logic            memRvalid,
  input  logic [XLEN-1:0] memRdata
);

  // A zero timeout still needs a one-bit counter so the logic stays well formed
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic [2:0]       lat_f3;
  logic [1:0]       lat_lo;
  logic [XLEN-1:0]  aligned_data;
  logic             timed_out;

  // Aligns the returning word using the offset and size latched at issue
  load_align u_load_align (
    .rdata  (memRdata),
    .addrLo (lat_lo),
    .funct3 (lat_f3),
    .result (aligned_data)
  );

  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  // Combinational so the pipeline freezes in the same cycle the instruction arrives
  assign stall = ((state == IDLE) && loadStore) || (state == REQ) || (state == RESP);

  // Access sequencer with registered bus and completion outputs
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_f3     <= '0;
      lat_lo     <= '0;
      memReq     <= 1'b0;
      memWe      <= 1'b0;
      memAddr    <= '0;
      memBe      <= '0;
      memWdata   <= '0;
      opDone     <= 1'b0;
      loadData   <= '0;
      misaligned <= 1'b0;
      busErr     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (loadStore) begin
            lat_we <= memWrite;
            lat_f3 <= funct3;
            lat_lo <= addr[1:0];
            if (is_misaligned(funct3[1:0], addr[1:0])) begin
              state      <= DONE;
              opDone     <= 1'b1;
              misaligned <= 1'b1;
              loadData   <= '0;
            end else begin
              state    <= REQ;
              memReq   <= 1'b1;
              memWe    <= memWrite;
              memAddr  <= {addr[XLEN-1:2], 2'b00};
              memBe    <= byte_enables(funct3[1:0], addr[1:0]);
              memWdata <= store_lanes(funct3[1:0], storeData);
            end
          end
        end

        REQ: begin
          if (memReady) begin
            memReq <= 1'b0;
            memWe  <= 1'b0;
            if (lat_we) begin
              state    <= DONE;
              opDone   <= 1'b1;
              loadData <= '0;
            end else if (memRvalid) begin
              state    <= DONE;
              opDone   <= 1'b1;
              loadData <= aligned_data;
            end else begin
              state <= RESP;
              cnt   <= cnt + 1'b1;
            end
          end else if (timed_out) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            state    <= DONE;
            opDone   <= 1'b1;
            busErr   <= 1'b1;
            loadData <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RESP: begin
          if (memRvalid) begin
            state    <= DONE;
            opDone   <= 1'b1;
            loadData <= aligned_data;
          end else if (timed_out) begin
            state    <= DONE;
            opDone   <= 1'b1;
            busErr   <= 1'b1;
            loadData <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          state      <= IDLE;
          cnt        <= '0;
          opDone     <= 1'b0;
          misaligned <= 1'b0;
          busErr     <= 1'b0;
          loadData   <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single accesses
// plus hand-written reset/stray-response sequences.
module tb_load_store_unit;

  logic        clk;
  logic        rstN;
  logic        loadStore;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        stall;
  logic        opDone;
  logic [31:0] loadData;
  logic        misaligned;
  logic        busErr;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWdata;
  logic        memReady;
  logic        memRvalid;
  logic [31:0] memRdata;

  int checks;
  int failures;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          ready_cyc;
    int          rvalid_cyc;
    int          done_cyc;
    bit          exp_req;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
    bit          exp_mis;
    bit          exp_err;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .loadStore  (loadStore),
    .memWrite   (memWrite),
    .funct3     (funct3),
    .addr       (addr),
    .storeData  (storeData),
    .stall      (stall),
    .opDone     (opDone),
    .loadData   (loadData),
    .misaligned (misaligned),
    .busErr     (busErr),
    .memReq     (memReq),
    .memWe      (memWe),
    .memAddr    (memAddr),
    .memBe      (memBe),
    .memWdata   (memWdata),
    .memReady   (memReady),
    .memRvalid  (memRvalid),
    .memRdata   (memRdata)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Runs one access from IDLE; bus responses arrive on the vector's chosen cycles
  task automatic apply_stimulus(input int idx, input vec_t v);
    bit done_seen;
    bit req_seen;
    loadStore = 1'b1;
    memWrite  = v.we;
    funct3    = v.f3;
    addr      = v.addr;
    storeData = v.sd;
    done_seen = 1'b0;
    req_seen  = 1'b0;
    for (int cyc = 0; cyc < 12 && !done_seen; cyc++) begin
      memReady  = (cyc == v.ready_cyc);
      memRvalid = (cyc == v.rvalid_cyc);
      memRdata  = (cyc == v.rvalid_cyc) ? v.rdata : 32'h0;
      @(negedge clk);
      check_output($sformatf("v%0d stall c%0d", idx, cyc), {31'b0, stall}, {31'b0, cyc < v.done_cyc});
      if (memReq && !req_seen) begin
        req_seen = 1'b1;
        check_output($sformatf("v%0d memWe", idx), {31'b0, memWe}, {31'b0, v.we});
        check_output($sformatf("v%0d memAddr", idx), memAddr, v.exp_maddr);
        check_output($sformatf("v%0d memBe", idx), {28'b0, memBe}, {28'b0, v.exp_be});
        check_output($sformatf("v%0d memWdata", idx), memWdata, v.exp_wdata);
      end
      if (opDone) begin
        done_seen = 1'b1;
        check_output($sformatf("v%0d done cycle", idx), cyc, v.done_cyc);
        check_output($sformatf("v%0d loadData", idx), loadData, v.exp_load);
        check_output($sformatf("v%0d misaligned", idx), {31'b0, misaligned}, {31'b0, v.exp_mis});
        check_output($sformatf("v%0d busErr", idx), {31'b0, busErr}, {31'b0, v.exp_err});
        check_output($sformatf("v%0d memReq in done", idx), {31'b0, memReq}, 32'h0);
      end
      @(posedge clk);
      #1;
    end
    check_output($sformatf("v%0d opDone seen", idx), {31'b0, done_seen}, 32'h1);
    check_output($sformatf("v%0d request issued", idx), {31'b0, req_seen}, {31'b0, v.exp_req});
    loadStore = 1'b0;
    memReady  = 1'b0;
    memRvalid = 1'b0;
    memRdata  = 32'h0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rstN      = 1'b0;
    loadStore = 1'b0;
    memWrite  = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    storeData = 32'h0;
    memReady  = 1'b0;
    memRvalid = 1'b0;
    memRdata  = 32'h0;

    //            we    f3      addr          sd            rdata        rdy rv  dn req maddr         be       wdata         load          mis err
    vecs[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1, 99, 2, 1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0, 0};
    vecs[1]  = '{1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        1, 99, 2, 1, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 32'h0,        0, 0};
    vecs[2]  = '{1'b0, 3'b000, 32'h0000_0201, 32'h0,         32'h0000_8000, 1, 2,  3, 1, 32'h0000_0200, 4'b0010, 32'h0,         32'hFFFF_FF80, 0, 0};
    vecs[3]  = '{1'b0, 3'b100, 32'h0000_0201, 32'h0,         32'h0000_8000, 1, 2,  3, 1, 32'h0000_0200, 4'b0010, 32'h0,         32'h0000_0080, 0, 0};
    vecs[4]  = '{1'b0, 3'b001, 32'h0000_0302, 32'h0,         32'h8001_0000, 1, 1,  2, 1, 32'h0000_0300, 4'b1100, 32'h0,         32'hFFFF_8001, 0, 0};
    vecs[5]  = '{1'b0, 3'b010, 32'h0000_0105, 32'h0,         32'h0,        99, 99, 1, 0, 32'h0,         4'b0000, 32'h0,         32'h0,        1, 0};
    vecs[6]  = '{1'b1, 3'b001, 32'h0000_0002, 32'h1234_ABCD, 32'h0,        3, 99, 4, 1, 32'h0000_0000, 4'b1100, 32'hABCD_ABCD, 32'h0,        0, 0};
    vecs[7]  = '{1'b0, 3'b010, 32'h0000_040C, 32'h0,         32'h1234_5678, 1, 3,  4, 1, 32'h0000_040C, 4'b1111, 32'h0,         32'h1234_5678, 0, 0};
    vecs[8]  = '{1'b0, 3'b101, 32'h0000_0201, 32'h0,         32'h0,        99, 99, 1, 0, 32'h0,         4'b0000, 32'h0,         32'h0,        1, 0};
    vecs[9]  = '{1'b0, 3'b100, 32'h0000_0203, 32'h0,         32'hFE00_0000, 1, 1,  2, 1, 32'h0000_0200, 4'b1000, 32'h0,         32'h0000_00FE, 0, 0};
    vecs[10] = '{1'b1, 3'b011, 32'h0000_0000, 32'h1111_1111, 32'h0,        99, 99, 1, 0, 32'h0,         4'b0000, 32'h0,         32'h0,        1, 0};
    vecs[11] = '{1'b0, 3'b010, 32'h0000_0500, 32'h0,         32'h0,        99, 99, 5, 1, 32'h0000_0500, 4'b1111, 32'h0,         32'h0,        0, 1};
    vecs[12] = '{1'b1, 3'b000, 32'h0000_0001, 32'h0000_0077, 32'h0,        99, 99, 5, 1, 32'h0000_0000, 4'b0010, 32'h7777_7777, 32'h0,        0, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset stall", {31'b0, stall}, 32'h0);
    check_output("reset memReq", {31'b0, memReq}, 32'h0);
    check_output("reset memWe", {31'b0, memWe}, 32'h0);
    check_output("reset opDone", {31'b0, opDone}, 32'h0);
    check_output("reset flags", {30'b0, misaligned, busErr}, 32'h0);
    check_output("reset memAddr", memAddr, 32'h0);
    check_output("reset memBe", {28'b0, memBe}, 32'h0);
    check_output("reset memWdata", memWdata, 32'h0);
    check_output("reset loadData", loadData, 32'h0);
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // Vectors run back to back: each starts in the IDLE cycle right after the previous DONE
    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(i, vecs[i]);
    end

    // Reset while a load waits in RESP, then a stray read response
    loadStore = 1'b1;
    memWrite  = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h0000_0600;
    storeData = 32'h0;
    @(posedge clk);
    #1;
    memReady = 1'b1;
    @(negedge clk);
    check_output("rst-resp memReq in REQ", {31'b0, memReq}, 32'h1);
    @(posedge clk);
    #1;
    memReady = 1'b0;
    @(negedge clk);
    check_output("rst-resp memReq in RESP", {31'b0, memReq}, 32'h0);
    check_output("rst-resp stall in RESP", {31'b0, stall}, 32'h1);
    rstN      = 1'b0;
    loadStore = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    @(negedge clk);
    check_output("rst-resp memReq after reset", {31'b0, memReq}, 32'h0);
    check_output("rst-resp stall after reset", {31'b0, stall}, 32'h0);
    check_output("rst-resp opDone after reset", {31'b0, opDone}, 32'h0);
    @(posedge clk);
    #1;
    memRvalid = 1'b1;
    memRdata  = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    memRvalid = 1'b0;
    memRdata  = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output($sformatf("stray rvalid opDone c%0d", k), {31'b0, opDone}, 32'h0);
      check_output($sformatf("stray rvalid stall c%0d", k), {31'b0, stall}, 32'h0);
    end

    // A fresh access after the abandoned one behaves normally
    @(posedge clk);
    #1;
    apply_stimulus(NVEC, vecs[4]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hang anywhere in the sequence
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
